// File: rtl/fofb_readout_writer.sv
// FOFB readout producer: collects per-BPM X/Y/S words into a ping-pong buffer and serves the completed bank.
// Optional FOFB_READOUT_ZERO_MISSING_EN: reads of BPMs missing from the readout bank return zero.
module fofb_readout_writer #(
    parameter int ADDR_WIDTH     = 9,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int HOLDOFF_CYCLES = 544
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cycleStart,
    input  logic [ADDR_WIDTH:0]      expectedCount,
    input  logic [TIMEOUT_WIDTH-1:0] timeoutTicks,
    input  logic                     useFakeData,
    input  logic                     overrunClear,
    input  logic                     bpmStrobe,
    input  logic [ADDR_WIDTH-1:0]    bpmIndex,
    input  logic [31:0]              bpmX,
    input  logic [31:0]              bpmY,
    input  logic [31:0]              bpmS,
    output logic [31:0]              fofbReadoutCSR,
    input  logic [ADDR_WIDTH-1:0]    readoutAddress,
    output logic [31:0]              readoutX,
    output logic [31:0]              readoutY,
    output logic [31:0]              readoutS
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int HW    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HW'(HOLDOFF_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLDOFF} state_t;
    state_t state, state_nxt;

    logic                         wr_bank;
    logic                         rd_bank;
    logic [1:0][DEPTH-1:0]        bitmap;
    logic [1:0][ADDR_WIDTH:0]     count;
    logic [TIMEOUT_WIDTH-1:0]     tmo_cnt;
    logic [HW-1:0]                hold_cnt;
    logic                         csr_active, csr_valid, csr_timeout, csr_overrun;
    logic [95:0]                  mem [2*DEPTH];
    logic [95:0]                  rd_q;

    logic start_col, accept_wr, new_entry, complete, tmo_hit, swap, overrun_set;

    assign rd_bank = ~wr_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Completion takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_nxt   = state;
        start_col   = 1'b0;
        accept_wr   = 1'b0;
        complete    = 1'b0;
        tmo_hit     = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (cycleStart) begin
                    start_col = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                accept_wr   = bpmStrobe;
                overrun_set = cycleStart;
                if (count[wr_bank] == expectedCount) complete = 1'b1;
                else if (tmo_cnt == '0)              tmo_hit  = 1'b1;
                if (complete || tmo_hit) state_nxt = HOLDOFF;
            end
            HOLDOFF: begin
                overrun_set = cycleStart;
                if (hold_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign swap      = complete | tmo_hit;
    assign new_entry = accept_wr & ~bitmap[wr_bank][bpmIndex];

    // A write in the swap cycle still lands in the outgoing bank (wr_bank is the pre-swap value).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            bitmap      <= '0;
            count       <= '0;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            csr_active  <= 1'b0;
            csr_valid   <= 1'b0;
            csr_timeout <= 1'b0;
            csr_overrun <= 1'b0;
        end else begin
            if (start_col) begin
                bitmap[wr_bank] <= '0;
                count[wr_bank]  <= '0;
                tmo_cnt         <= timeoutTicks;
                csr_active      <= 1'b1;
                csr_valid       <= 1'b0;
                csr_timeout     <= 1'b0;
            end else if (state == COLLECT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            if (new_entry) begin
                bitmap[wr_bank][bpmIndex] <= 1'b1;
                count[wr_bank]            <= count[wr_bank] + 1'b1;
            end

            if (swap) begin
                wr_bank     <= ~wr_bank;
                csr_active  <= 1'b0;
                csr_valid   <= complete;
                csr_timeout <= tmo_hit;
                hold_cnt    <= HOLD_LOAD;
            end else if (state == HOLDOFF && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            if (overrunClear)     csr_overrun <= 1'b0;
            else if (overrun_set) csr_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_wr) mem[{wr_bank, bpmIndex}] <= {bpmX, bpmY, bpmS};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
`ifdef FOFB_READOUT_ZERO_MISSING_EN
            rd_q <= bitmap[rd_bank][readoutAddress] ? mem[{rd_bank, readoutAddress}] : '0;
`else
            rd_q <= mem[{rd_bank, readoutAddress}];
`endif
        end
    end

    assign readoutX = rd_q[95:64];
    assign readoutY = rd_q[63:32];
    assign readoutS = rd_q[31:0];

    assign fofbReadoutCSR = {csr_active, csr_valid, csr_timeout, csr_overrun, 7'd0,
                             useFakeData, 4'd0, 16'(count[rd_bank])};
endmodule

// File: tb/tb_fofb_readout_writer.sv
// Self-checking bench for fofb_readout_writer against a bank-level behavioural model.
module tb_fofb_readout_writer;
    localparam int AW   = 9;
    localparam int TW   = 16;
    localparam int HOLD = 544;
    localparam int N    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cycleStart = 1'b0;
    logic [AW:0]   expectedCount = '0;
    logic [TW-1:0] timeoutTicks = '0;
    logic          useFakeData = 1'b0;
    logic          overrunClear = 1'b0;
    logic          bpmStrobe = 1'b0;
    logic [AW-1:0] bpmIndex = '0;
    logic [31:0]   bpmX = '0, bpmY = '0, bpmS = '0;
    logic [31:0]   fofbReadoutCSR;
    logic [AW-1:0] readoutAddress = '0;
    logic [31:0]   readoutX, readoutY, readoutS;

    fofb_readout_writer #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW), .HOLDOFF_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .cycleStart(cycleStart), .expectedCount(expectedCount),
        .timeoutTicks(timeoutTicks), .useFakeData(useFakeData), .overrunClear(overrunClear),
        .bpmStrobe(bpmStrobe), .bpmIndex(bpmIndex), .bpmX(bpmX), .bpmY(bpmY), .bpmS(bpmS),
        .fofbReadoutCSR(fofbReadoutCSR), .readoutAddress(readoutAddress),
        .readoutX(readoutX), .readoutY(readoutY), .readoutS(readoutS)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: two banks of last-written words plus which indices arrived in the bank's latest cycle
    logic [95:0] m_mem [2][N];
    bit          m_bmp [2][N];
    int          m_wr  = 0;
    bit          m_ovr = 1'b0;

    function automatic int m_count(int b);
        int c = 0;
        for (int i = 0; i < N; i++) if (m_bmp[b][i]) c++;
        return c;
    endfunction

    function automatic logic [95:0] exp_read(int idx);
`ifdef FOFB_READOUT_ZERO_MISSING_EN
        return m_bmp[1-m_wr][idx] ? m_mem[1-m_wr][idx] : 96'd0;
`else
        return m_mem[1-m_wr][idx];
`endif
    endfunction

    function automatic logic [31:0] csr_word(bit a, bit v, bit t, int cnt);
        return {a, v, t, m_ovr, 7'd0, useFakeData, 4'd0, 16'(cnt)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle;
        cycleStart = 1'b1;
        tick();
        cycleStart = 1'b0;
        for (int i = 0; i < N; i++) m_bmp[m_wr][i] = 1'b0;
    endtask

    task automatic drive_write(input int idx, input logic [95:0] d);
        bpmStrobe = 1'b1;
        bpmIndex  = AW'(idx);
        {bpmX, bpmY, bpmS} = d;
        tick();
        bpmStrobe = 1'b0;
        m_mem[m_wr][idx] = d;
        m_bmp[m_wr][idx] = 1'b1;
    endtask

    task automatic wait_holdoff;
        repeat (HOLD + 16) tick();
    endtask

    task automatic test_reset;
        useFakeData = 1'b1;
        #1;
        checks++;
        if (fofbReadoutCSR !== 32'h0010_0000) begin
            errors++; $display("FAIL reset_csr_fake got=%h want=%h", fofbReadoutCSR, 32'h0010_0000);
        end
        useFakeData = 1'b0;
        #1;
        checks++;
        if (fofbReadoutCSR !== 32'h0) begin
            errors++; $display("FAIL reset_csr got=%h want=0", fofbReadoutCSR);
        end
        checks++;
        if ({readoutX, readoutY, readoutS} !== 96'd0) begin
            errors++; $display("FAIL reset_readout got=%h want=0", {readoutX, readoutY, readoutS});
        end
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_complete;
        int idxs [3] = '{5, 7, 9};
        useFakeData   = 1'b0;
        expectedCount = 3;
        timeoutTicks  = 1000;
        start_cycle();
        checks++;
        if (fofbReadoutCSR !== csr_word(1, 0, 0, 0)) begin
            errors++; $display("FAIL complete_start got=%h want=%h", fofbReadoutCSR, csr_word(1, 0, 0, 0));
        end
        foreach (idxs[k]) drive_write(idxs[k], {$urandom, $urandom, $urandom});
        checks++;
        if (fofbReadoutCSR[31] !== 1'b1) begin
            errors++; $display("FAIL complete_active_hold got=%b want=1", fofbReadoutCSR[31]);
        end
        tick();
        m_wr = 1 - m_wr;
        checks++;
        if (fofbReadoutCSR !== csr_word(0, 1, 0, 3)) begin
            errors++; $display("FAIL complete_swap got=%h want=%h", fofbReadoutCSR, csr_word(0, 1, 0, 3));
        end
        foreach (idxs[k]) begin
            readoutAddress = AW'(idxs[k]);
            tick();
            checks++;
            if ({readoutX, readoutY, readoutS} !== exp_read(idxs[k])) begin
                errors++; $display("FAIL complete_read idx=%0d got=%h want=%h", idxs[k],
                                   {readoutX, readoutY, readoutS}, exp_read(idxs[k]));
            end
        end
        wait_holdoff();
    endtask

    task automatic test_random_complete;
        for (int it = 0; it < 4; it++) begin
            int exp_n;
            bit done;
            exp_n = $urandom_range(1, 6);
            done = 1'b0;
            useFakeData   = $urandom_range(0, 1);
            expectedCount = (AW+1)'(exp_n);
            timeoutTicks  = 2000;
            start_cycle();
            for (int s = 0; s < 60 && !done; s++) begin
                if ($urandom_range(0, 3) == 0) tick();
                else drive_write($urandom_range(0, 15), {$urandom, $urandom, $urandom});
                done = (m_count(m_wr) == exp_n);
                checks++;
                if (fofbReadoutCSR[31] !== 1'b1) begin
                    errors++; $display("FAIL rand_active it=%0d step=%0d got=%b want=1", it, s, fofbReadoutCSR[31]);
                end
            end
            tick();
            m_wr = 1 - m_wr;
            checks++;
            if (fofbReadoutCSR !== csr_word(0, 1, 0, exp_n)) begin
                errors++; $display("FAIL rand_swap it=%0d got=%h want=%h", it, fofbReadoutCSR, csr_word(0, 1, 0, exp_n));
            end
            for (int i = 0; i < 16; i++) begin
                if (m_bmp[1-m_wr][i]) begin
                    readoutAddress = AW'(i);
                    tick();
                    checks++;
                    if ({readoutX, readoutY, readoutS} !== exp_read(i)) begin
                        errors++; $display("FAIL rand_read it=%0d idx=%0d got=%h want=%h", it, i,
                                           {readoutX, readoutY, readoutS}, exp_read(i));
                    end
                end
            end
            wait_holdoff();
        end
    endtask

    task automatic test_timeout;
        int a, b;
        a = $urandom_range(0, 255);
        b = a + 256;
        useFakeData   = 1'b1;
        expectedCount = 4;
        timeoutTicks  = 100;
        start_cycle();
        drive_write(a, {$urandom, $urandom, $urandom});
        drive_write(b, {$urandom, $urandom, $urandom});
        repeat (98) tick();
        checks++;
        if (fofbReadoutCSR[31] !== 1'b1) begin
            errors++; $display("FAIL timeout_early got=%b want=1", fofbReadoutCSR[31]);
        end
        tick();
        m_wr = 1 - m_wr;
        checks++;
        if (fofbReadoutCSR !== csr_word(0, 0, 1, 2)) begin
            errors++; $display("FAIL timeout_flags got=%h want=%h", fofbReadoutCSR, csr_word(0, 0, 1, 2));
        end
        readoutAddress = AW'(b);
        tick();
        checks++;
        if ({readoutX, readoutY, readoutS} !== exp_read(b)) begin
            errors++; $display("FAIL timeout_read got=%h want=%h", {readoutX, readoutY, readoutS}, exp_read(b));
        end
        wait_holdoff();
    endtask

    // ends right after the swap edge so the overrun test can time from it
    task automatic test_duplicate;
        useFakeData   = 1'b0;
        expectedCount = 2;
        timeoutTicks  = 50;
        start_cycle();
        drive_write(5, {$urandom, $urandom, $urandom});
        drive_write(5, {$urandom, $urandom, $urandom});
        repeat (48) tick();
        checks++;
        if (fofbReadoutCSR[31] !== 1'b1) begin
            errors++; $display("FAIL dup_no_complete got=%b want=1", fofbReadoutCSR[31]);
        end
        tick();
        m_wr = 1 - m_wr;
        checks++;
        if (fofbReadoutCSR !== csr_word(0, 0, 1, 1)) begin
            errors++; $display("FAIL dup_timeout got=%h want=%h", fofbReadoutCSR, csr_word(0, 0, 1, 1));
        end
    endtask

    task automatic test_overrun;
        readoutAddress = 5;
        tick();
        checks++;
        if ({readoutX, readoutY, readoutS} !== exp_read(5)) begin
            errors++; $display("FAIL dup_read got=%h want=%h", {readoutX, readoutY, readoutS}, exp_read(5));
        end
        repeat (8) tick();
        cycleStart = 1'b1;
        tick();
        cycleStart = 1'b0;
        checks++;
        if (fofbReadoutCSR[31:28] !== 4'b0011) begin
            errors++; $display("FAIL overrun_set got=%b want=0011", fofbReadoutCSR[31:28]);
        end
        overrunClear = 1'b1;
        tick();
        overrunClear = 1'b0;
        checks++;
        if (fofbReadoutCSR[28] !== 1'b0) begin
            errors++; $display("FAIL overrun_clear got=%b want=0", fofbReadoutCSR[28]);
        end
        cycleStart = 1'b1;
        overrunClear = 1'b1;
        tick();
        cycleStart = 1'b0;
        overrunClear = 1'b0;
        checks++;
        if (fofbReadoutCSR[28] !== 1'b0) begin
            errors++; $display("FAIL overrun_clear_wins got=%b want=0", fofbReadoutCSR[28]);
        end
        repeat (HOLD + 16 - 12) tick();
        expectedCount = 0;
        timeoutTicks  = 100;
        start_cycle();
        checks++;
        if (fofbReadoutCSR !== csr_word(1, 0, 0, 1)) begin
            errors++; $display("FAIL late_start got=%h want=%h", fofbReadoutCSR, csr_word(1, 0, 0, 1));
        end
        tick();
        m_wr = 1 - m_wr;
        checks++;
        if (fofbReadoutCSR !== csr_word(0, 1, 0, 0)) begin
            errors++; $display("FAIL zero_expected got=%h want=%h", fofbReadoutCSR, csr_word(0, 1, 0, 0));
        end
        wait_holdoff();
    endtask

    task automatic test_missing;
        timeoutTicks = 500;
        for (int c = 0; c < 3; c++) begin
            expectedCount = (c == 2) ? 1 : 2;
            start_cycle();
            if (c != 2) drive_write(3, {$urandom, $urandom, $urandom});
            drive_write(4, {$urandom, $urandom, $urandom});
            tick();
            m_wr = 1 - m_wr;
            checks++;
            if (fofbReadoutCSR[31:30] !== 2'b01) begin
                errors++; $display("FAIL missing_swap c=%0d got=%b want=01", c, fofbReadoutCSR[31:30]);
            end
            if (c != 2) wait_holdoff();
        end
        for (int i = 3; i <= 4; i++) begin
            readoutAddress = AW'(i);
            tick();
            checks++;
            if ({readoutX, readoutY, readoutS} !== exp_read(i)) begin
                errors++; $display("FAIL missing_read idx=%0d got=%h want=%h", i,
                                   {readoutX, readoutY, readoutS}, exp_read(i));
            end
        end
        wait_holdoff();
    endtask

    task automatic test_reset_mid;
        useFakeData   = 1'b1;
        expectedCount = 10;
        timeoutTicks  = 1000;
        start_cycle();
        drive_write($urandom_range(0, N-1), {$urandom, $urandom, $urandom});
        #2 rst = 1'b1;
        #1;
        checks++;
        if (fofbReadoutCSR !== 32'h0010_0000) begin
            errors++; $display("FAIL midreset_csr got=%h want=%h", fofbReadoutCSR, 32'h0010_0000);
        end
        checks++;
        if ({readoutX, readoutY, readoutS} !== 96'd0) begin
            errors++; $display("FAIL midreset_readout got=%h want=0", {readoutX, readoutY, readoutS});
        end
        #2 rst = 1'b0;
        m_wr = 0;
        m_ovr = 1'b0;
        for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) m_bmp[b][i] = 1'b0;
        tick();
        useFakeData = 1'b0;
        start_cycle();
        checks++;
        if (fofbReadoutCSR !== csr_word(1, 0, 0, 0)) begin
            errors++; $display("FAIL midreset_restart got=%h want=%h", fofbReadoutCSR, csr_word(1, 0, 0, 0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_complete();
        test_random_complete();
        test_timeout();
        test_duplicate();
        test_overrun();
        test_missing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
